// File: rtl/spi_master_engine.sv
// SPI master shift engine: pops words from the bridge TX FIFO, shifts them out MSB first
// (CPHA=0), captures MISO and pushes each received word into the bridge RX FIFO.
module spi_master_engine #(
  parameter int   DATA_WIDTH = 32,
  parameter int   CLK_DIV    = 4,
  parameter logic CPOL       = 1'b0,
  parameter int   CS_GAP     = 2
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  empty_tx,
  input  logic [DATA_WIDTH-1:0] fifo_r_data_tx,
  output logic                  read_fifo_tx,
  input  logic                  full_rx,
  output logic                  write_fifo_rx,
  output logic [DATA_WIDTH-1:0] fifo_w_data_rx,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  busy
);

  localparam int HW = $clog2(CLK_DIV) + 1;
  localparam int BW = $clog2(DATA_WIDTH) + 1;
  localparam int GW = $clog2(CS_GAP) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, PUSH, GAP} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic [DATA_WIDTH-1:0] rx_sr;
  logic [HW-1:0]         half_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [GW-1:0]         gap_cnt;
  logic                  miso_meta;
  logic                  miso_sync;
  logic                  start_ok;

  // full_rx is checked before a word is popped, so a received word always has room
  assign start_ok       = !empty_tx && !full_rx;
  assign read_fifo_tx   = presetn && start_ok && ((state == IDLE) || (state == PUSH));
  assign write_fifo_rx  = (state == PUSH);
  assign fifo_w_data_rx = rx_sr;
  assign mosi           = tx_sr[DATA_WIDTH-1];
  assign busy           = (state != IDLE);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      miso_meta <= 1'b0;
      miso_sync <= 1'b0;
    end else begin
      miso_meta <= miso;
      miso_sync <= miso_meta;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state    <= IDLE;
      tx_sr    <= '0;
      rx_sr    <= '0;
      half_cnt <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      sclk     <= CPOL;
      cs_n     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            tx_sr    <= fifo_r_data_tx;
            half_cnt <= '0;
            bit_cnt  <= '0;
            cs_n     <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (half_cnt == HW'(CLK_DIV - 1)) begin
            half_cnt <= '0;
            sclk     <= ~sclk;
            // leaving the idle level samples, returning to it shifts the next bit out
            if (sclk == CPOL) begin
              rx_sr <= {rx_sr[DATA_WIDTH-2:0], miso_sync};
            end else begin
              tx_sr   <= tx_sr << 1;
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
                state <= PUSH;
              end
            end
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        PUSH: begin
          if (start_ok) begin
            tx_sr    <= fifo_r_data_tx;
            half_cnt <= '0;
            bit_cnt  <= '0;
            state    <= SHIFT;
          end else begin
            cs_n    <= 1'b1;
            gap_cnt <= '0;
            state   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == GW'(CS_GAP - 1)) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_engine.sv
// Directed bench for spi_master_engine: a CPOL=0 instance in loopback and a CPOL=1
// instance with miso tied low, fed from a show-ahead TX FIFO model.
module tb_spi_master_engine;

  logic        pclk;
  logic        presetn;
  logic        full_rx;
  logic        loopback;
  logic        sel_b;
  logic        tx_empty;
  logic [31:0] head;

  logic        empty_a, read_a, wr_a, sclk_a, cs_a, mosi_a, miso_a, busy_a;
  logic [31:0] wdata_a;
  logic        empty_b, read_b, wr_b, sclk_b, cs_b, mosi_b, miso_b, busy_b;
  logic [31:0] wdata_b;

  logic        m_read, m_wr, m_sclk, m_cs, m_mosi, m_busy;
  logic [31:0] m_wdata;

  assign empty_a = sel_b ? 1'b1 : tx_empty;
  assign empty_b = sel_b ? tx_empty : 1'b1;
  assign miso_a  = loopback ? mosi_a : 1'b0;
  assign miso_b  = 1'b0;

  assign m_read  = sel_b ? read_b  : read_a;
  assign m_wr    = sel_b ? wr_b    : wr_a;
  assign m_wdata = sel_b ? wdata_b : wdata_a;
  assign m_sclk  = sel_b ? sclk_b  : sclk_a;
  assign m_cs    = sel_b ? cs_b    : cs_a;
  assign m_mosi  = sel_b ? mosi_b  : mosi_a;
  assign m_busy  = sel_b ? busy_b  : busy_a;

  spi_master_engine #(.DATA_WIDTH(32), .CLK_DIV(4), .CPOL(1'b0), .CS_GAP(2)) dut_a (
    .pclk(pclk), .presetn(presetn), .empty_tx(empty_a), .fifo_r_data_tx(head),
    .read_fifo_tx(read_a), .full_rx(full_rx), .write_fifo_rx(wr_a),
    .fifo_w_data_rx(wdata_a), .sclk(sclk_a), .cs_n(cs_a), .mosi(mosi_a),
    .miso(miso_a), .busy(busy_a)
  );

  spi_master_engine #(.DATA_WIDTH(32), .CLK_DIV(4), .CPOL(1'b1), .CS_GAP(2)) dut_b (
    .pclk(pclk), .presetn(presetn), .empty_tx(empty_b), .fifo_r_data_tx(head),
    .read_fifo_tx(read_b), .full_rx(full_rx), .write_fifo_rx(wr_b),
    .fifo_w_data_rx(wdata_b), .sclk(sclk_b), .cs_n(cs_b), .mosi(mosi_b),
    .miso(miso_b), .busy(busy_b)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] txq[$];
  logic        pop_pending = 1'b0;
  logic        full_req = 1'b0;
  logic        rst_req = 1'b0;

  int          cyc, n_pop, n_wr, n_lead, n_edges, n_cs_fall, n_cs_rise;
  int          n_mosi_chg, n_bad_mosi, busy_hi_cnt;
  int          t_cs_fall, t_cs_rise, t_idle;
  int          t_pop[0:7];
  int          t_wr[0:7];
  int          t_lead[0:127];
  logic [31:0] rx_d[0:7];
  logic        prev_sclk, prev_cs, prev_mosi, prev_wr, prev_busy;

  task automatic clear_stats();
    cyc = 0; n_pop = 0; n_wr = 0; n_lead = 0; n_edges = 0;
    n_cs_fall = 0; n_cs_rise = 0; n_mosi_chg = 0; n_bad_mosi = 0; busy_hi_cnt = 0;
    t_cs_fall = -1; t_cs_rise = -1; t_idle = -1;
    for (int i = 0; i < 8; i++) begin
      t_pop[i] = -1; t_wr[i] = -1; rx_d[i] = 32'hxxxxxxxx;
    end
    for (int i = 0; i < 128; i++) t_lead[i] = -1;
    prev_sclk = m_sclk; prev_cs = m_cs; prev_mosi = m_mosi;
    prev_wr = m_wr; prev_busy = m_busy;
  endtask

  // One cycle: inputs change just after the falling edge, outputs are sampled 1 ns later
  task automatic tick();
    @(negedge pclk);
    if (pop_pending && txq.size() > 0) txq.delete(0);
    pop_pending = 1'b0;
    full_rx  = full_req;
    presetn  = rst_req;
    tx_empty = (txq.size() == 0);
    head     = (txq.size() > 0) ? txq[0] : 32'h0;
    #1;
    cyc++;
    if (m_read) begin
      if (n_pop < 8) t_pop[n_pop] = cyc;
      n_pop++;
      pop_pending = 1'b1;
    end
    if (m_wr) begin
      if (n_wr < 8) begin t_wr[n_wr] = cyc; rx_d[n_wr] = m_wdata; end
      n_wr++;
    end
    if (m_sclk !== prev_sclk) begin
      n_edges++;
      if (prev_sclk == sel_b) begin
        if (n_lead < 128) t_lead[n_lead] = cyc;
        n_lead++;
      end
    end
    if (m_mosi !== prev_mosi) begin
      n_mosi_chg++;
      if (!((m_sclk !== prev_sclk) && (m_sclk == sel_b)) && !prev_cs && !prev_wr) n_bad_mosi++;
    end
    if (!m_cs && prev_cs) begin n_cs_fall++; t_cs_fall = cyc; end
    if (m_cs && !prev_cs) begin n_cs_rise++; t_cs_rise = cyc; end
    if (m_busy) busy_hi_cnt++;
    if (!m_busy && prev_busy) t_idle = cyc;
    prev_sclk = m_sclk; prev_cs = m_cs; prev_mosi = m_mosi;
    prev_wr = m_wr; prev_busy = m_busy;
  endtask

  task automatic run_until_writes(input int n, input int budget);
    for (int i = 0; i < budget && n_wr < n; i++) tick();
  endtask

  task automatic test_reset();
    presetn = 1'b0; rst_req = 1'b0; full_req = 1'b0; full_rx = 1'b0;
    sel_b = 1'b0; loopback = 1'b1; tx_empty = 1'b1; head = 32'h0;
    repeat (3) @(negedge pclk);
    #1;
    n_checks++; if (sclk_a !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_sclk_a: got %b expected 0", sclk_a); end
    n_checks++; if (sclk_b !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_sclk_b: got %b expected 1", sclk_b); end
    n_checks++; if (cs_a !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_cs_n: got %b expected 1", cs_a); end
    n_checks++; if (mosi_a !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mosi: got %b expected 0", mosi_a); end
    n_checks++; if (read_a !== 1'b0 || wr_a !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pulses: read %b write %b expected 0 0", read_a, wr_a); end
    n_checks++; if (wdata_a !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_rx_data: got %h expected 00000000", wdata_a); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_a); end
    rst_req = 1'b1;
    tick();
    tick();
    clear_stats();
  endtask

  task automatic test_single_word();
    sel_b = 1'b0; loopback = 1'b1;
    clear_stats();
    txq.push_back(32'hA5A50F0F);
    run_until_writes(1, 400);
    repeat (6) tick();
    n_checks++; if (n_pop !== 1 || n_wr !== 1) begin n_fail++; $display("[TB] FAIL single_counts: pops %0d writes %0d expected 1 1", n_pop, n_wr); end
    n_checks++; if (rx_d[0] !== 32'hA5A50F0F) begin n_fail++; $display("[TB] FAIL single_rx_data: got %h expected a5a50f0f", rx_d[0]); end
    n_checks++; if (t_wr[0] - t_pop[0] !== 257) begin n_fail++; $display("[TB] FAIL single_write_latency: got %0d expected 257", t_wr[0] - t_pop[0]); end
    n_checks++; if (t_cs_fall - t_pop[0] !== 1) begin n_fail++; $display("[TB] FAIL single_cs_fall: got %0d expected 1", t_cs_fall - t_pop[0]); end
    n_checks++; if (t_lead[0] - t_pop[0] !== 5) begin n_fail++; $display("[TB] FAIL single_first_lead: got %0d expected 5", t_lead[0] - t_pop[0]); end
    n_checks++; if (n_lead !== 32 || n_edges !== 64) begin n_fail++; $display("[TB] FAIL single_sclk_pulses: lead %0d edges %0d expected 32 64", n_lead, n_edges); end
    n_checks++; if (t_cs_rise - t_wr[0] !== 1) begin n_fail++; $display("[TB] FAIL single_cs_rise: got %0d expected 1", t_cs_rise - t_wr[0]); end
    n_checks++; if (t_idle - t_wr[0] !== 3) begin n_fail++; $display("[TB] FAIL single_gap_len: got %0d expected 3", t_idle - t_wr[0]); end
    n_checks++; if (m_cs !== 1'b1 || m_sclk !== 1'b0) begin n_fail++; $display("[TB] FAIL single_idle_lines: cs_n %b sclk %b expected 1 0", m_cs, m_sclk); end
  endtask

  task automatic test_burst();
    sel_b = 1'b0; loopback = 1'b1;
    clear_stats();
    txq.push_back(32'h00000001);
    txq.push_back(32'h80000000);
    txq.push_back(32'hFFFFFFFF);
    run_until_writes(3, 1200);
    repeat (6) tick();
    n_checks++; if (n_pop !== 3 || n_wr !== 3) begin n_fail++; $display("[TB] FAIL burst_counts: pops %0d writes %0d expected 3 3", n_pop, n_wr); end
    n_checks++; if (rx_d[0] !== 32'h00000001) begin n_fail++; $display("[TB] FAIL burst_rx0: got %h expected 00000001", rx_d[0]); end
    n_checks++; if (rx_d[1] !== 32'h80000000) begin n_fail++; $display("[TB] FAIL burst_rx1: got %h expected 80000000", rx_d[1]); end
    n_checks++; if (rx_d[2] !== 32'hFFFFFFFF) begin n_fail++; $display("[TB] FAIL burst_rx2: got %h expected ffffffff", rx_d[2]); end
    n_checks++; if (n_cs_fall !== 1 || n_cs_rise !== 1) begin n_fail++; $display("[TB] FAIL burst_cs_toggles: falls %0d rises %0d expected 1 1", n_cs_fall, n_cs_rise); end
    n_checks++; if (t_pop[1] !== t_wr[0] || t_pop[2] !== t_wr[1]) begin n_fail++; $display("[TB] FAIL burst_pop_in_push: pops %0d %0d pushes %0d %0d", t_pop[1], t_pop[2], t_wr[0], t_wr[1]); end
    n_checks++; if (t_lead[32] - t_wr[0] !== 5) begin n_fail++; $display("[TB] FAIL burst_next_lead: got %0d expected 5", t_lead[32] - t_wr[0]); end
    n_checks++; if (t_wr[1] - t_wr[0] !== 257 || n_lead !== 96) begin n_fail++; $display("[TB] FAIL burst_spacing: got %0d lead %0d expected 257 96", t_wr[1] - t_wr[0], n_lead); end
  endtask

  task automatic test_backpressure();
    sel_b = 1'b0; loopback = 1'b1;
    clear_stats();
    full_req = 1'b1;
    txq.push_back(32'h0F0F1234);
    txq.push_back(32'hDEADBEEF);
    repeat (20) tick();
    n_checks++; if (n_pop !== 0) begin n_fail++; $display("[TB] FAIL bp_no_pop: got %0d pops expected 0", n_pop); end
    n_checks++; if (n_cs_fall !== 0 || busy_hi_cnt !== 0) begin n_fail++; $display("[TB] FAIL bp_idle: cs falls %0d busy cycles %0d expected 0 0", n_cs_fall, busy_hi_cnt); end
    clear_stats();
    full_req = 1'b0;
    tick();
    n_checks++; if (t_pop[0] !== 1) begin n_fail++; $display("[TB] FAIL bp_release_pop: got cycle %0d expected 1", t_pop[0]); end
    run_until_writes(2, 800);
    repeat (6) tick();
    n_checks++; if (t_cs_fall !== 2) begin n_fail++; $display("[TB] FAIL bp_cs_fall: got cycle %0d expected 2", t_cs_fall); end
    n_checks++; if (n_pop !== 2 || rx_d[0] !== 32'h0F0F1234 || rx_d[1] !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL bp_data: pops %0d rx %h %h expected 2 0f0f1234 deadbeef", n_pop, rx_d[0], rx_d[1]); end
  endtask

  task automatic test_mode_cpol1();
    sel_b = 1'b1;
    tick();
    clear_stats();
    n_checks++; if (m_sclk !== 1'b1) begin n_fail++; $display("[TB] FAIL cpol1_idle: got sclk %b expected 1", m_sclk); end
    txq.push_back(32'h3C96F00D);
    run_until_writes(1, 400);
    repeat (6) tick();
    n_checks++; if (n_wr !== 1 || rx_d[0] !== 32'h0) begin n_fail++; $display("[TB] FAIL cpol1_rx: writes %0d data %h expected 1 00000000", n_wr, rx_d[0]); end
    n_checks++; if (n_lead !== 32 || t_wr[0] - t_pop[0] !== 257) begin n_fail++; $display("[TB] FAIL cpol1_timing: lead %0d latency %0d expected 32 257", n_lead, t_wr[0] - t_pop[0]); end
    n_checks++; if (n_bad_mosi !== 0 || n_mosi_chg !== 14) begin n_fail++; $display("[TB] FAIL cpol1_mosi: off-edge changes %0d total %0d expected 0 14", n_bad_mosi, n_mosi_chg); end
    n_checks++; if (m_sclk !== 1'b1 || m_cs !== 1'b1) begin n_fail++; $display("[TB] FAIL cpol1_end_idle: sclk %b cs_n %b expected 1 1", m_sclk, m_cs); end
    sel_b = 1'b0;
  endtask

  task automatic test_reset_mid_word();
    sel_b = 1'b0; loopback = 1'b1;
    clear_stats();
    txq.push_back(32'h12345678);
    txq.push_back(32'hCAFEF00D);
    for (int i = 0; i < 300 && n_edges < 10; i++) tick();
    n_checks++; if (n_edges !== 10) begin n_fail++; $display("[TB] FAIL midrst_edges: got %0d expected 10", n_edges); end
    presetn = 1'b0;
    rst_req = 1'b0;
    #1;
    n_checks++; if (cs_a !== 1'b1 || sclk_a !== 1'b0 || busy_a !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_async: cs_n %b sclk %b busy %b expected 1 0 0", cs_a, sclk_a, busy_a); end
    clear_stats();
    repeat (3) tick();
    n_checks++; if (n_pop !== 0 || n_wr !== 0) begin n_fail++; $display("[TB] FAIL midrst_quiet: pops %0d writes %0d expected 0 0", n_pop, n_wr); end
    rst_req = 1'b1;
    run_until_writes(1, 400);
    repeat (6) tick();
    n_checks++; if (n_pop !== 1 || n_wr !== 1 || rx_d[0] !== 32'hCAFEF00D) begin n_fail++; $display("[TB] FAIL midrst_next_word: pops %0d writes %0d data %h expected 1 1 cafef00d", n_pop, n_wr, rx_d[0]); end
  endtask

  task automatic test_empty_tx();
    sel_b = 1'b0;
    clear_stats();
    repeat (1000) tick();
    n_checks++; if (n_pop !== 0 || n_wr !== 0) begin n_fail++; $display("[TB] FAIL empty_pulses: pops %0d writes %0d expected 0 0", n_pop, n_wr); end
    n_checks++; if (busy_hi_cnt !== 0 || n_cs_fall !== 0 || m_cs !== 1'b1) begin n_fail++; $display("[TB] FAIL empty_idle: busy cycles %0d cs falls %0d cs_n %b expected 0 0 1", busy_hi_cnt, n_cs_fall, m_cs); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_burst();
    test_backpressure();
    test_mode_cpol1();
    test_reset_mid_word();
    test_empty_tx();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
